// File: rtl/mult_seq_ctrl.sv
// Sequencing FSM for the shift-add multiplier: drives load/add_en/shift per multiplier bit.
// Latency: load one cycle after start is accepted; done 2 + 2*WIDTH + popcount(multiplier) cycles after acceptance.
// Backpressure: start is only sampled in IDLE; abort returns to IDLE on the next edge from any busy state.
module mult_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          q0,
  output logic          load,
  output logic          add_en,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] bit_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] ADD   = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  // Count value seen in the final SHIFT, before its increment.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;

  // Next-state selection; abort overrides normal sequencing everywhere but IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = CHECK;
      CHECK:   state_nxt = q0 ? ADD : SHIFT;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (bit_cnt == LAST_BIT) ? DONE : CHECK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end
  end

  // State register plus Moore outputs decoded from the next state so they are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      load   <= 1'b0;
      add_en <= 1'b0;
      shift  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      load   <= (state_nxt == LOAD);
      add_en <= (state_nxt == ADD);
      shift  <= (state_nxt == SHIFT);
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
    end
  end

  // Shift counter: cleared as LOAD is entered, bumped as each SHIFT completes, frozen by abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (state_nxt == LOAD) begin
      bit_cnt <= '0;
    end else if ((state == SHIFT) && !abort) begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: drives operations, models the product register, and scores each operation.
// Latency: expected cycles derived from the per-bit timing rules with plain arithmetic.
// Backpressure: start noise is injected while busy; extra loads or missing done pulses are flagged.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          q0;
  logic          load;
  logic          add_en;
  logic          shift;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_cnt;

  always #5 clock = ~clock;

  mult_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .q0      (q0),
    .load    (load),
    .add_en  (add_en),
    .shift   (shift),
    .busy    (busy),
    .done    (done),
    .bit_cnt (bit_cnt)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Product shift register and adder controlled by the DUT.
  logic [2*WIDTH:0]  prod_reg   = '0;
  logic [WIDTH-1:0]  mplier_cur = '0;
  logic [WIDTH-1:0]  mcand_cur  = '0;
  assign q0 = prod_reg[0];

  always @(posedge clock) begin
    if (load)
      prod_reg <= {{(WIDTH+1){1'b0}}, mplier_cur};
    else if (add_en)
      prod_reg[2*WIDTH:WIDTH] <= prod_reg[2*WIDTH:WIDTH] + {1'b0, mcand_cur};
    else if (shift)
      prod_reg <= prod_reg >> 1;
  end

  typedef struct {
    int load_cyc;
    bit exp_done;
    int done_cyc;
    int product;
    int adds;
    int shifts;
    int end_cnt;
    int fall_cyc;
  } exp_t;

  exp_t sb[$];
  int   exp_dones = 0;
  int   obs_dones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Timing rules: LOAD is cycle 1, each bit is CHECK [+ADD] + SHIFT. Counts events at or before cycle k.
  function automatic void sched(input int m, input int k, output int adds, output int sh_le, output int sh_lt);
    int t;
    t = 1; adds = 0; sh_le = 0; sh_lt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      t++;
      if (((m >> i) & 1) == 1) begin
        t++;
        if (t <= k) adds++;
      end
      t++;
      if (t <= k) sh_le++;
      if (t < k)  sh_lt++;
    end
  endfunction

  function automatic exp_t full_op(input int ld, input int m, input int c);
    exp_t e;
    e.load_cyc = ld;
    e.exp_done = 1'b1;
    e.done_cyc = ld + 1 + 2*WIDTH + $countones(m[WIDTH-1:0]);
    e.product  = m * c;
    e.adds     = $countones(m[WIDTH-1:0]);
    e.shifts   = WIDTH;
    e.end_cnt  = WIDTH;
    e.fall_cyc = e.done_cyc + 1;
    return e;
  endfunction

  // Monitor: accumulates per-operation observations and scores them when busy falls.
  initial begin : monitor
    logic prev_busy;
    int   rise_cyc, n_load, n_add, n_shift, n_done, done_at, excl_bad, prod_at_done, cnt_at_done;
    exp_t e;
    prev_busy = 1'b0;
    rise_cyc = 0; n_load = 0; n_add = 0; n_shift = 0; n_done = 0;
    done_at = 0; excl_bad = 0; prod_at_done = 0; cnt_at_done = 0;
    forever begin
      @(negedge clock);
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
        rise_cyc = cyc; n_load = 0; n_add = 0; n_shift = 0; n_done = 0; excl_bad = 0;
      end
      if (load === 1'b1)   n_load++;
      if (add_en === 1'b1) n_add++;
      if (shift === 1'b1)  n_shift++;
      if ($countones({load, add_en, shift}) > 1) excl_bad++;
      if (done === 1'b1) begin
        n_done++;
        obs_dones++;
        done_at      = cyc;
        prod_at_done = int'(prod_reg[2*WIDTH-1:0]);
        cnt_at_done  = int'(bit_cnt);
      end
      if (prev_busy === 1'b1 && busy === 1'b0) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_op_end: got busy fall at cycle %0d expected no operation", cyc);
        end else begin
          e = sb.pop_front();
          chk("busy_rise_cycle", rise_cyc, e.load_cyc);
          chk("load_pulses", n_load, 1);
          chk("busy_fall_cycle", cyc, e.fall_cyc);
          chk("done_pulses", n_done, int'(e.exp_done));
          if (e.exp_done) begin
            chk("done_cycle", done_at, e.done_cyc);
            chk("product", prod_at_done, e.product);
            chk("bit_cnt_at_done", cnt_at_done, WIDTH);
          end
          chk("add_pulses", n_add, e.adds);
          chk("shift_pulses", n_shift, e.shifts);
          chk("bit_cnt_after", bit_cnt, e.end_cnt);
          chk("ctrl_exclusive", excl_bad, 0);
        end
      end
      prev_busy = busy;
    end
  end

  // Called at a falling edge; returns at the first falling edge with busy low.
  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b0) return;
      @(negedge clock);
    end
    tests++;
    failed++;
    $display("FAIL wait_idle_timeout: got busy=%0b expected 0 within 300 cycles", busy);
  endtask

  task automatic run_op(input int m, input int c, input bit noise);
    exp_t e;
    wait_idle();
    mplier_cur = m[WIDTH-1:0];
    mcand_cur  = c[WIDTH-1:0];
    start      = 1'b1;
    e = full_op(cyc + 1, m, c);
    sb.push_back(e);
    exp_dones++;
    @(negedge clock);
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) break;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic abort_op(input int m, input int k);
    exp_t e;
    int   adds, sh_le, sh_lt;
    wait_idle();
    mplier_cur = m[WIDTH-1:0];
    mcand_cur  = WIDTH'($urandom);
    start      = 1'b1;
    sched(m, k, adds, sh_le, sh_lt);
    e.load_cyc = cyc + 1;
    e.exp_done = 1'b0;
    e.done_cyc = 0;
    e.product  = 0;
    e.adds     = adds;
    e.shifts   = sh_le;
    e.end_cnt  = sh_lt;
    e.fall_cyc = e.load_cyc + k;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    repeat (k - 1) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy_low", busy, 0);
    chk("abort_no_done", done, 0);
    chk("abort_bit_cnt_frozen", bit_cnt, sh_lt);
  endtask

  task automatic reset_op();
    exp_t e;
    wait_idle();
    mplier_cur = '0;
    start      = 1'b1;
    e.load_cyc = cyc + 1;
    e.exp_done = 1'b0;
    e.done_cyc = 0;
    e.product  = 0;
    e.adds     = 0;
    e.shifts   = 4;
    e.end_cnt  = 0;
    e.fall_cyc = e.load_cyc + 9;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    chk("pre_reset_shift", shift, 1);
    chk("pre_reset_bit_cnt", bit_cnt, 3);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_reset_load", load, 0);
    chk("mid_reset_add_en", add_en, 0);
    chk("mid_reset_shift", shift, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_bit_cnt", bit_cnt, 0);
    reset = 1'b0;
  endtask

  task automatic back_to_back(input int m1, input int c1, input int m2, input int c2);
    exp_t e1, e2;
    wait_idle();
    mplier_cur = m1[WIDTH-1:0];
    mcand_cur  = c1[WIDTH-1:0];
    start      = 1'b1;
    e1 = full_op(cyc + 1, m1, c1);
    e2 = full_op(e1.done_cyc + 2, m2, c2);
    sb.push_back(e1);
    sb.push_back(e2);
    exp_dones += 2;
    while (cyc < e1.done_cyc) @(negedge clock);
    mplier_cur = m2[WIDTH-1:0];
    mcand_cur  = c2[WIDTH-1:0];
    while (cyc < e2.done_cyc) @(negedge clock);
    start = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of run expected completion before 500000 time units");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    @(negedge clock);
    chk("reset_load", load, 0);
    chk("reset_add_en", add_en, 0);
    chk("reset_shift", shift, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bit_cnt", bit_cnt, 0);
    reset = 1'b0;
    @(negedge clock);

    run_op(8'h00, int'($urandom_range(0, 255)), 1'b0);
    run_op(8'hFF, int'($urandom_range(0, 255)), 1'b0);
    run_op(8'hA5, 8'h3C, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
    end

    abort_op(8'h00, 10);
    run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
    abort_op(int'($urandom_range(0, 255)), int'($urandom_range(2, 15)));

    reset_op();
    run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);

    back_to_back(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    wait_idle();
    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    chk("total_done_pulses", obs_dones, exp_dones);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
